// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory request logic, prefetch
// queue with address tagging, and an optional ARM-style condition evaluator.
// Optional feature macro: FETCH_COND_EN.
//   defined   -> cond_pass evaluates ir[31:28] against nzcv
//   undefined -> cond_pass is tied to 1 and nzcv is ignored
// The queue is a shift queue: entry 0 is always the head, so ir/ir_pc come
// straight from registers with no read mux and no bypass from imem_rdata.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [3:0]        nzcv,
  input  logic              ir_ready,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              cond_pass,
  output logic [4:0]        q_count
);

  localparam int CNT_W = 5;
  localparam int OCC_W = 6;

  // Fetch-side state
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              inflight_reg;
  logic [ADDR_W-1:0] req_addr_reg;

  // Queue occupancy
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  // Queue storage; index 0 is the head
  logic [31:0]       q_instr_reg [DEPTH];
  logic [ADDR_W-1:0] q_pc_reg    [DEPTH];

  // Value each entry takes when the queue shifts towards the head
  logic [31:0]       shift_instr [DEPTH];
  logic [ADDR_W-1:0] shift_pc    [DEPTH];

  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  wr_idx;
  logic [OCC_W-1:0]  occupancy;
  logic [ADDR_W-1:0] redirect_target;

  // A consumed head leaves; an in-flight response lands unless a redirect kills it
  assign pop  = ir_valid && ir_ready;
  assign push = inflight_reg && !redirect;

  // When popping, everything moves down one slot, so the new word lands one lower
  assign wr_idx = count_reg - CNT_W'(pop);

  // Slots that will be committed after this edge if no new request is made
  assign occupancy = {1'b0, count_reg} + OCC_W'(inflight_reg) - OCC_W'(pop);

  // Request only when the response is guaranteed a free slot; never during
  // a redirect, and never while reset is held
  assign imem_req = !rst && !redirect && (occupancy < OCC_W'(DEPTH));

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign imem_addr = pc_reg;
  assign q_count   = count_reg;
  assign ir_valid  = (count_reg != '0);
  assign ir        = q_instr_reg[0];
  assign ir_pc     = q_pc_reg[0];

  // Next PC: redirect wins, otherwise step one word per issued request (wraps)
  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = redirect_target;
    end else if (imem_req) begin
      pc_next = pc_reg + ADDR_W'(4);
    end
  end

  // Next occupancy: redirect empties the queue, otherwise push/pop bookkeeping
  always_comb begin
    count_next = count_reg;
    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // PC, occupancy and in-flight tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      req_addr_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      count_reg    <= count_next;
      inflight_reg <= imem_req;
      req_addr_reg <= pc_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi < DEPTH - 1) begin : g_shift
        assign shift_instr[gi] = q_instr_reg[gi+1];
        assign shift_pc[gi]    = q_pc_reg[gi+1];
      end else begin : g_top
        assign shift_instr[gi] = q_instr_reg[gi];
        assign shift_pc[gi]    = q_pc_reg[gi];
      end

      // Entry update: load the returning word at the tail, else shift on pop
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_instr_reg[gi] <= '0;
          q_pc_reg[gi]    <= '0;
        end else if (push && (wr_idx == CNT_W'(gi))) begin
          q_instr_reg[gi] <= imem_rdata;
          q_pc_reg[gi]    <= req_addr_reg;
        end else if (pop && !redirect) begin
          q_instr_reg[gi] <= shift_instr[gi];
          q_pc_reg[gi]    <= shift_pc[gi];
        end
      end
    end
  endgenerate

`ifdef FETCH_COND_EN
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  assign flag_n = nzcv[3];
  assign flag_z = nzcv[2];
  assign flag_c = nzcv[1];
  assign flag_v = nzcv[0];

  // Evaluate the head instruction's condition field against the current flags
  always_comb begin
    cond_pass = 1'b1;
    case (ir[31:28])
      4'h0:    cond_pass = flag_z;
      4'h1:    cond_pass = !flag_z;
      4'h2:    cond_pass = flag_c;
      4'h3:    cond_pass = !flag_c;
      4'h4:    cond_pass = flag_n;
      4'h5:    cond_pass = !flag_n;
      4'h6:    cond_pass = flag_v;
      4'h7:    cond_pass = !flag_v;
      4'h8:    cond_pass = flag_c && !flag_z;
      4'h9:    cond_pass = !flag_c || flag_z;
      4'hA:    cond_pass = (flag_n == flag_v);
      4'hB:    cond_pass = (flag_n != flag_v);
      4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
      4'hD:    cond_pass = flag_z || (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end
`else
  // Evaluator absent: every instruction passes, flags are don't-care
  logic unused_nzcv;
  assign unused_nzcv = ^nzcv;
  assign cond_pass   = 1'b1;
`endif

  // Low redirect bits are forced to zero, so they are intentionally dropped
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a queue-based
// reference model that is checked against the 32-bit instance every cycle,
// plus a second 8-bit-address instance for PC wrap-around.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  nzcv;
  logic        ir_ready;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        cond_pass;
  logic [4:0]  q_count;

  logic        imem_req8;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_rdata8;
  logic        redirect8;
  logic [7:0]  redirect_pc8;
  logic        ir_valid8;
  logic [31:0] ir8;
  logic [7:0]  ir_pc8;
  logic        cond_pass8;
  logic [4:0]  q_count8;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .nzcv(nzcv), .ir_ready(ir_ready), .ir_valid(ir_valid), .ir(ir),
    .ir_pc(ir_pc), .cond_pass(cond_pass), .q_count(q_count)
  );

  fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h0)) u_dut8 (
    .clk(clk), .rst(rst), .imem_req(imem_req8), .imem_addr(imem_addr8),
    .imem_rdata(imem_rdata8), .redirect(redirect8), .redirect_pc(redirect_pc8),
    .nzcv(nzcv), .ir_ready(ir_ready), .ir_valid(ir_valid8), .ir(ir8),
    .ir_pc(ir_pc8), .cond_pass(cond_pass8), .q_count(q_count8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: condition nibble = addr[5:2], so addresses 0x00..0x3C
  // walk through every condition code
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[5:2], 4'hA, a[23:0]};
  endfunction

  function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
`ifdef FETCH_COND_EN
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (cc == cc) || (f != f);
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory: data valid the whole cycle after an accepted request
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? word(imem_addr) : 32'h0BAD_F00D;
    imem_rdata8 <= imem_req8 ? word({24'h0, imem_addr8}) : 32'h0BAD_F00D;
  end

  // Reference model: a queue of (pc, word) entries plus one pending response
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;

  initial begin
    bit   pop;
    bit   ereq;
    ent_t e;
    m_pc = 32'h0;
    m_pend = 1'b0;
    m_pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_count", q_count, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_pc", ir_pc, 0);
        m_pc = 32'h0;
        m_q.delete();
        m_pend = 1'b0;
      end else begin
        pop  = (m_q.size() != 0) && ir_ready;
        ereq = !redirect && ((m_q.size() + int'(m_pend) - int'(pop)) < DEPTH);
        chk("m_req", imem_req, ereq);
        chk("m_addr", imem_addr, m_pc);
        chk("m_valid", ir_valid, m_q.size() != 0);
        chk("m_count", q_count, 64'(m_q.size()));
        if (m_q.size() != 0) begin
          chk("m_ir", ir, m_q[0].w);
          chk("m_ir_pc", ir_pc, m_q[0].pc);
          chk("m_cond", cond_pass, cond_model(m_q[0].w[31:28], nzcv));
        end
        if (redirect) begin
          m_q.delete();
          m_pend = 1'b0;
          m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
          if (pop) void'(m_q.pop_front());
          if (m_pend) begin
            e.pc = m_pend_addr;
            e.w  = word(m_pend_addr);
            m_q.push_back(e);
          end
          m_pend = ereq;
          m_pend_addr = m_pc;
          if (ereq) m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (!ir_valid && k < 20) begin
      tick();
      k++;
    end
    chk(nm, ir_valid, 1'b1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect = 1'b1;
    redirect_pc = target;
    tick();
    redirect = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    redirect8 = 1'b0;
    redirect_pc8 = 8'h0;
    nzcv = 4'h0;
    ir_ready = 1'b1;
    repeat (3) tick();

    // Reset release with ir_ready=1: streaming fetch, one instruction per cycle
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      $display("release cycle %0d: req=%0b addr=%0h valid=%0b ir_pc=%0h", i, imem_req, imem_addr, ir_valid, ir_pc);
      chk("rel_addr", imem_addr, 32'(4 * i));
      chk("rel_req", imem_req, 1'b1);
      chk("rel_valid", ir_valid, i >= 2);
      if (i >= 2) chk("rel_ir_pc", ir_pc, 32'(4 * (i - 2)));
      tick();
    end

    // Streaming with varying flags exercises every condition code
    for (int i = 0; i < 24; i++) begin
      nzcv = 4'($urandom_range(0, 15));
      tick();
    end

    // Back-pressure: exactly DEPTH requests, then one more per single pop
    ir_ready = 1'b0;
    do_redirect(32'h200);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) n++;
      tick();
    end
    $display("backpressure: %0d requests, q_count=%0d", n, q_count);
    chk("fill_reqs", n, 4);
    chk("fill_count", q_count, 4);
    chk("fill_req_low", imem_req, 1'b0);
    ir_ready = 1'b1;
    #1;
    n = 0;
    if (imem_req) n++;
    tick();
    ir_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (imem_req) n++;
      tick();
    end
    $display("single pop: %0d extra requests", n);
    chk("pop1_reqs", n, 1);
    chk("pop1_count", q_count, 4);

    // Redirect while three entries are queued and one response is in flight
    do_redirect(32'h0);
    repeat (4) tick();
    chk("pre_redir_count", q_count, 3);
    chk("pre_redir_req", imem_req, 1'b0);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("redir_req", imem_req, 1'b0);
    tick();
    redirect = 1'b0;
    #1;
    $display("after redirect: count=%0d valid=%0b addr=%0h req=%0b", q_count, ir_valid, imem_addr, imem_req);
    chk("redir_count", q_count, 0);
    chk("redir_valid", ir_valid, 1'b0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_req_resume", imem_req, 1'b1);
    ir_ready = 1'b1;
    wait_valid("redir_wait");
    chk("redir_ir_pc", ir_pc, 32'h100);
    chk("redir_ir", ir, word(32'h100));

    // Condition evaluation on a held head
    ir_ready = 1'b0;
    do_redirect(32'h0);
    wait_valid("eq_wait");
    chk("eq_nibble", ir[31:28], 4'h0);
    nzcv = 4'b0100;
    #1;
    chk("eq_z1", cond_pass, 1'b1);
    nzcv = 4'b0000;
    #1;
`ifdef FETCH_COND_EN
    chk("eq_z0", cond_pass, 1'b0);
`else
    chk("eq_z0", cond_pass, 1'b1);
`endif
    do_redirect(32'h30);
    wait_valid("gt_wait");
    chk("gt_nibble", ir[31:28], 4'hC);
    chk("gt_ir_pc", ir_pc, 32'h30);
    nzcv = 4'b1001;
    #1;
    chk("gt_nv", cond_pass, 1'b1);
    nzcv = 4'b0100;
    #1;
`ifdef FETCH_COND_EN
    chk("gt_z", cond_pass, 1'b0);
`else
    chk("gt_z", cond_pass, 1'b1);
`endif
    $display("cond checks done: ir=%0h nzcv=%0b cond_pass=%0b", ir, nzcv, cond_pass);

    // 8-bit address wrap: 0xFC is followed by 0x00
    ir_ready = 1'b1;
    redirect8 = 1'b1;
    redirect_pc8 = 8'hFD;
    #1;
    chk("w8_redir_req", imem_req8, 1'b0);
    tick();
    redirect8 = 1'b0;
    #1;
    chk("w8_addr_fc", imem_addr8, 8'hFC);
    chk("w8_req", imem_req8, 1'b1);
    tick();
    $display("wrap: imem_addr8=%0h", imem_addr8);
    chk("w8_addr_wrap", imem_addr8, 8'h00);
    k = 0;
    while (!ir_valid8 && k < 20) begin
      tick();
      k++;
    end
    chk("w8_valid", ir_valid8, 1'b1);
    chk("w8_ir_pc_fc", ir_pc8, 8'hFC);
    chk("w8_ir_fc", ir8, word(32'hFC));
    chk("w8_cond", cond_pass8, cond_model(ir8[31:28], nzcv));
    tick();
    chk("w8_ir_pc_00", ir_pc8, 8'h00);

    // Asynchronous reset mid-operation with two entries queued
    ir_ready = 1'b0;
    do_redirect(32'h400);
    repeat (3) tick();
    chk("pre_rst_count", q_count, 2);
    rst = 1'b1;
    #1;
    $display("async reset: valid=%0b count=%0d req=%0b", ir_valid, q_count, imem_req);
    chk("arst_valid", ir_valid, 1'b0);
    chk("arst_count", q_count, 0);
    chk("arst_req", imem_req, 1'b0);
    chk("arst_count8", q_count8, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", imem_req, 1'b1);
    ir_ready = 1'b1;
    wait_valid("post_rst_wait");
    chk("post_rst_ir_pc", ir_pc, 32'h0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC and instruction-address width (range 8..32).
REQ-002 Parameter DEPTH, default 4, prefetch queue entries (power of 2, range 2..16).
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset (word aligned).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 imem_req  out  1  fetch request, sampled by instruction memory at the rising edge.
REQ-007 imem_addr  out  ADDR_W  byte address of the requested word.
REQ-008 imem_rdata  in  32  instruction word, valid the whole cycle after an accepted request.
REQ-009 redirect  in  1  branch or exception redirect, one-cycle pulse.
REQ-010 redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0.
REQ-011 nzcv  in  4  flags, N=bit3, Z=bit2, C=bit1, V=bit0.
REQ-012 ir_ready  in  1  consumer accepts the head instruction this cycle.
REQ-013 ir_valid  out  1  queue head is valid.
REQ-014 ir  out  32  queue-head instruction word.
REQ-015 ir_pc  out  ADDR_W  address of the queue-head instruction.
REQ-016 cond_pass  out  1  condition field ir[31:28] is satisfied by the current nzcv.
REQ-017 q_count  out  5  number of queue entries occupied.

Function
REQ-018 PC register: imem_addr = PC; PC advances by 4 (mod 2^ADDR_W, wrapping silently) on each edge where imem_req=1.
REQ-019 imem_req = !redirect && (q_count + inflight - pop < DEPTH), where pop = ir_valid && ir_ready and inflight = a request was issued at the previous edge and has not been flushed.
REQ-020 Response data from imem_rdata, tagged with its request address, is pushed into the queue at the edge after the request, unless it has been flushed.
REQ-021 Latency: request issued at edge N; entry written at edge N+1; ir_valid=1 during cycle N+1 after that edge. There is no output bypass.
REQ-022 ir_valid = (q_count != 0); ir and ir_pc are the head entry, driven from registers.
REQ-023 Pop when ir_valid && ir_ready; a simultaneous push and pop leaves q_count unchanged; the queue never overflows or underflows.
REQ-024 Sustained throughput is one instruction per cycle when ir_ready is held at 1.
REQ-025 Redirect, which takes priority over every other event in the same cycle:
- the queue is emptied;
- any in-flight response is discarded;
- PC is loaded with {redirect_pc[ADDR_W-1:2], 2'b00};
- imem_req=0 in the redirect cycle;
- fetching resumes the next cycle.
REQ-026 A pop in a redirect cycle is still a legal consumption; the entry is then flushed with the rest of the queue.
REQ-027 cond_pass is combinational from ir[31:28] and nzcv:
- 0 EQ = Z; 1 NE = !Z;
- 2 CS = C; 3 CC = !C;
- 4 MI = N; 5 PL = !N;
- 6 VS = V; 7 VC = !V;
- 8 HI = C&!Z; 9 LS = !C|Z;
- A GE = N==V; B LT = N!=V;
- C GT = !Z&(N==V); D LE = Z|(N!=V);
- E and F = 1.
REQ-028 cond_pass is meaningful only when ir_valid=1; the block never drops an entry because of its condition, so the consumer decides.

Reset
REQ-029 While rst=1:
- PC=RESET_PC;
- queue empty, q_count=0, inflight cleared;
- ir_valid=0, ir=0, ir_pc=0;
- imem_req=0.
REQ-030 Reset asserted mid-operation takes effect immediately, discards queue contents and any in-flight response, and leaves no partial state.
REQ-031 The first request (addr=RESET_PC) is issued in the first cycle after rst deasserts.

Configuration
REQ-032 Macro FETCH_COND_EN, when defined, enables the condition evaluator as specified in REQ-027.
REQ-033 When FETCH_COND_EN is undefined, cond_pass is tied to 1, the nzcv input is ignored, and no evaluator logic is synthesised.

Verification
REQ-034 Bench scenarios:
- Reset release with RESET_PC=0 and ir_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; ir_pc 0,4,8 one per cycle; ir_valid first rises one edge after the first request edge.
- ir_ready=0 with DEPTH=4 -> exactly 4 requests are issued, then imem_req=0 and q_count=4; raising ir_ready for 1 cycle -> exactly 1 further request.
- Redirect to 0x103 while q_count=3 and a response is in flight -> next cycle q_count=0, the stale word is never output, the next imem_addr=0x100, and the next ir_pc=0x100.
- Head ir=0x0xxxxxxx (EQ): nzcv=4'b0100 -> cond_pass=1; nzcv=0 -> cond_pass=0. ir=0xCxxxxxxx with nzcv=4'b1001 -> cond_pass=1. The same checks without FETCH_COND_EN -> cond_pass=1 in every case.
- ADDR_W=8 with PC=0xFC -> next imem_addr=0x00, no error.
- rst pulsed while q_count=2 -> ir_valid=0 and q_count=0 asynchronously; after release the first imem_addr=RESET_PC.
